// File: rtl/spram32_bridge_if.sv
// Request/response bundle between the RV32I word memory port and the SPRAM bridge.
// The master issues valid/ready word requests; the slave answers with a one-cycle
// rsp_valid pulse (no response backpressure).
interface spram32_bridge_if;
   logic        req_valid;
   logic        req_ready;
   logic [12:0] req_addr;
   logic        req_we;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   modport master (
      output req_valid,
      output req_addr,
      output req_we,
      output req_be,
      output req_wdata,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_we,
      input  req_be,
      input  req_wdata,
      output req_ready,
      output rsp_valid,
      output rsp_rdata
   );
endinterface

// File: rtl/spram32_bridge.sv
// spram32_bridge: splits each 32-bit word access into up to two 16-bit accesses on a
// single 16K x 16 SPRAM, low half first. Byte enables become SPRAM nibble masks.
// All SPRAM-facing controls come straight from flops, loaded with the values for the
// state being entered, so the SPRAM sees clean registered inputs.
module spram32_bridge #(
   parameter bit FAST_WRITE = 1'b1
) (
   input  logic               clk,
   input  logic               resetb,
   spram32_bridge_if.slave    bus,
   output logic [13:0]        spram_addr,
   output logic [15:0]        spram_din,
   output logic [3:0]         spram_maskwren,
   output logic               spram_wren,
   input  logic [15:0]        spram_dout
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACC_LO = 2'd1,
      ST_ACC_HI = 2'd2,
      ST_RSP    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [12:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] lo_q, lo_d;
   logic [13:0] spram_addr_q, spram_addr_d;
   logic [15:0] spram_din_q, spram_din_d;
   logic [3:0]  mask_q, mask_d;
   logic        wren_q, wren_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        accept_s;

   // Two enabled bytes of one 16-bit half map onto four SPRAM nibble write enables.
   function automatic logic [3:0] be_to_mask(input logic [1:0] be_pair);
      return {be_pair[1], be_pair[1], be_pair[0], be_pair[0]};
   endfunction

   // Next-state, capture and SPRAM-control computation for the state being entered.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      spram_addr_d = spram_addr_q;
      spram_din_d  = spram_din_q;
      mask_d       = 4'b0000;
      wren_d       = 1'b0;
      rsp_valid_d  = 1'b0;
      accept_s     = bus.req_valid && (state_q == ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               addr_d  = bus.req_addr;
               we_d    = bus.req_we;
               be_d    = bus.req_be;
               wdata_d = bus.req_wdata;
               if (FAST_WRITE && bus.req_we && (bus.req_be == 4'b0000)) begin
                  state_d = ST_RSP;
               end else if (FAST_WRITE && bus.req_we && (bus.req_be[1:0] == 2'b00)) begin
                  state_d = ST_ACC_HI;
               end else begin
                  state_d = ST_ACC_LO;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACC_LO: begin
            if (FAST_WRITE && we_q && (be_q[3:2] == 2'b00)) begin
               state_d = ST_RSP;
            end else begin
               state_d = ST_ACC_HI;
            end
         end
         ST_ACC_HI: begin
            // The low-half read issued in ACC_LO is on spram_dout now.
            if (!we_q) begin
               lo_d = spram_dout;
            end else begin
               lo_d = lo_q;
            end
            state_d = ST_RSP;
         end
         ST_RSP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // SPRAM controls registered for the state entered on the next edge; IDLE/RSP
      // keep the last address and never write.
      case (state_d)
         ST_ACC_LO: begin
            spram_addr_d = {addr_d, 1'b0};
            spram_din_d  = wdata_d[15:0];
            wren_d       = we_d;
            mask_d       = we_d ? be_to_mask(be_d[1:0]) : 4'b0000;
         end
         ST_ACC_HI: begin
            spram_addr_d = {addr_d, 1'b1};
            spram_din_d  = wdata_d[31:16];
            wren_d       = we_d;
            mask_d       = we_d ? be_to_mask(be_d[3:2]) : 4'b0000;
         end
         ST_RSP: begin
            rsp_valid_d = 1'b1;
         end
         default: begin
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q      <= ST_IDLE;
         addr_q       <= 13'd0;
         we_q         <= 1'b0;
         be_q         <= 4'b0000;
         wdata_q      <= 32'h0000_0000;
         lo_q         <= 16'h0000;
         spram_addr_q <= 14'd0;
         spram_din_q  <= 16'h0000;
         mask_q       <= 4'b0000;
         wren_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         spram_addr_q <= spram_addr_d;
         spram_din_q  <= spram_din_d;
         mask_q       <= mask_d;
         wren_q       <= wren_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   // Write strobes are qualified by resetb so a reset raised mid-access stops the
   // half in flight from being committed on the same edge that resets the bridge.
   assign spram_wren     = wren_q & resetb;
   assign spram_maskwren = mask_q & {4{resetb}};
   assign spram_addr     = spram_addr_q;
   assign spram_din      = spram_din_q;

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   // High half arrives from the SPRAM in the RSP cycle itself; low half was parked in lo_q.
   assign bus.rsp_rdata  = (rsp_valid_q && !we_q) ? {spram_dout, lo_q} : 32'h0000_0000;

endmodule
